// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit and the ALU control decoder.
// Build option: define ALU_MUL_EN to include the iterative multiplier
// (code 4'b1000 and the MUL state).
package alu_pkg;

  // 4-bit ALU control codes produced by the ALU control decoder
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  // Execution FSM states; MUL exists only when the multiplier is built in
`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DONE = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// Instantiated by alu_exec_unit only when ALU_MUL_EN is defined.
// start_i loads the operands; the DATA_W following cycles each retire one bit.
// done_o is high during the final iteration and product_o then carries the
// complete low DATA_W bits of the unsigned product.
module alu_mul_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic              busy_q,   busy_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [DATA_W-1:0] acc_q,    acc_d;
  logic [DATA_W-1:0] mcand_q,  mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] step_acc;
  logic              last_step;

  // Partial-product accumulation for the current multiplier bit
  always_comb begin
    step_acc  = acc_q + (mplier_q[0] ? mcand_q : '0);
    last_step = busy_q && (cnt_q == CNT_W'(DATA_W - 1));
  end

  // Next-state: load on start, otherwise shift one bit per busy cycle
  always_comb begin
    // NOTE: every signal is given its hold value first so no latch is inferred.
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = a_i;
      mplier_d = b_i;
    end else if (busy_q) begin
      acc_d    = step_acc;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (last_step) begin
        busy_d = 1'b0;
      end
    end
  end

  // Multiplier state registers
  always_ff @(posedge clk_i or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = last_step;
  assign product_o = step_acc;

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit with valid/ready handshakes on both sides.
// Single-cycle ops: AND, OR, ADD, SUB, SLT. Unknown codes give result 0.
// Build option: define ALU_MUL_EN to add code 4'b1000 (MUL) executed by
// alu_mul_iter over DATA_W cycles; without it 4'b1000 is an unknown code.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [3:0]        ALUctrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              ovf_o
);

  state_t            state_q,  state_d;
  logic              ready_q,  ready_d;
  logic              valid_q,  valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              ovf_q,    ovf_d;

  logic              accept;
  logic [DATA_W-1:0] sum, diff;
  logic              slt;
  logic [DATA_W-1:0] alu_result;
  logic              alu_ovf;

  assign accept = valid_i && ready_q;

`ifdef ALU_MUL_EN
  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;

  assign mul_start = accept && (ALUctrl_i == ALU_MUL);

  alu_mul_iter #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .a_i       (src1_i),
    .b_i       (src2_i),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );
`endif

  // Single-cycle ALU result and signed-overflow flag from the live operands
  always_comb begin
    sum        = src1_i + src2_i;
    diff       = src1_i - src2_i;
    slt        = $signed(src1_i) < $signed(src2_i);
    alu_result = '0;
    alu_ovf    = 1'b0;
    case (ALUctrl_i)
      ALU_AND: alu_result = src1_i & src2_i;
      ALU_OR:  alu_result = src1_i | src2_i;
      ALU_ADD: begin
        alu_result = sum;
        alu_ovf    = (src1_i[DATA_W-1] == src2_i[DATA_W-1]) &&
                     (sum[DATA_W-1] != src1_i[DATA_W-1]);
      end
      ALU_SUB: begin
        alu_result = diff;
        alu_ovf    = (src1_i[DATA_W-1] != src2_i[DATA_W-1]) &&
                     (diff[DATA_W-1] != src1_i[DATA_W-1]);
      end
      ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, slt};
      default: begin
        alu_result = '0;
        alu_ovf    = 1'b0;
      end
    endcase
  end

  // FSM next state; the result registers load only on a state transition into DONE
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef ALU_MUL_EN
          if (ALUctrl_i == ALU_MUL) begin
            state_d = ST_MUL;
          end else
`endif
          begin
            state_d  = ST_DONE;
            result_d = alu_result;
            ovf_d    = alu_ovf;
          end
        end
      end
`ifdef ALU_MUL_EN
      ST_MUL: begin
        if (mul_done) begin
          state_d  = ST_DONE;
          result_d = mul_product;
          ovf_d    = 1'b0;
        end else if (!mul_busy) begin
          // Multiplier idle without finishing: recover rather than hang
          state_d = ST_IDLE;
        end
      end
`endif
      ST_DONE: begin
        if (ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_DONE);
  end

  // FSM and registered outputs; reset discards any pending result
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign zero_o   = (result_q == '0);
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit (DATA_W = 32).
// Multiply expectations follow ALU_MUL_EN when the bench is built with it.
module tb_alu_exec_unit;

  localparam int DATA_W = 32;

  logic              clk_i;
  logic              rst_n;
  logic              valid_i;
  logic              ready_o;
  logic [3:0]        ALUctrl_i;
  logic [DATA_W-1:0] src1_i;
  logic [DATA_W-1:0] src2_i;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] result_o;
  logic              zero_o;
  logic              ovf_o;

  int checks   = 0;
  int failures = 0;

  alu_exec_unit #(.DATA_W(DATA_W)) dut (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .ALUctrl_i (ALUctrl_i),
    .src1_i    (src1_i),
    .src2_i    (src2_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .result_o  (result_o),
    .zero_o    (zero_o),
    .ovf_o     (ovf_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one op for one cycle; returns #1 after the accepting edge
  task automatic run_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    ALUctrl_i = ctrl;
    src1_i    = a;
    src2_i    = b;
    valid_i   = 1'b1;
    @(posedge clk_i); #1;
    valid_i   = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [31:0] res,
                              input logic zero, input logic ovf);
    check({tag, "_valid"}, valid_o, 1'b1);
    check({tag, "_ready"}, ready_o, 1'b0);
    check({tag, "_result"}, result_o, res);
    check({tag, "_zero"}, zero_o, zero);
    check({tag, "_ovf"}, ovf_o, ovf);
  endtask

  // Downstream takes the result; unit must be idle on the next cycle
  task automatic consume(input string tag);
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    check({tag, "_drain_valid"}, valid_o, 1'b0);
    check({tag, "_drain_ready"}, ready_o, 1'b1);
  endtask

`ifdef ALU_MUL_EN
  task automatic mul_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int n;
    run_op(4'b1000, a, b);
    check({tag, "_busy_ready"}, ready_o, 1'b0);
    n = 0;
    while (valid_o !== 1'b1 && n < 40) begin
      @(posedge clk_i); #1;
      n++;
    end
    // valid in cycle accept+33: 32 edges after the accepting edge
    check({tag, "_latency"}, n, 32);
    check_result(tag, exp, exp == 0, 1'b0);
    consume(tag);
  endtask
`endif

  initial begin
    int bad;
    rst_n     = 1'b0;
    valid_i   = 1'b0;
    ready_i   = 1'b0;
    ALUctrl_i = 4'b0000;
    src1_i    = '0;
    src2_i    = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", valid_o, 1'b0);
    check("rst_result", result_o, 32'h0);
    check("rst_zero", zero_o, 1'b1);
    check("rst_ovf", ovf_o, 1'b0);
    rst_n = 1'b1;
    @(posedge clk_i); #1;
    check("rst_ready", ready_o, 1'b1);
    check("rst_valid_after", valid_o, 1'b0);

    // ADD overflow boundary, latency 1
    run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    check_result("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
    consume("add_ovf");

    run_op(4'b0110, 32'd5, 32'd5);
    check_result("sub_zero", 32'h0, 1'b1, 1'b0);
    consume("sub_zero");

    run_op(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001);
    check_result("slt_neg", 32'h1, 1'b0, 1'b0);
    consume("slt_neg");

    run_op(4'b0111, 32'h0000_0001, 32'hFFFF_FFFF);
    check_result("slt_pos", 32'h0, 1'b1, 1'b0);
    consume("slt_pos");

    run_op(4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
    check_result("and", 32'h0000_F000, 1'b0, 1'b0);
    consume("and");

    run_op(4'b0001, 32'h0000_F0F0, 32'h0000_0F00);
    check_result("or", 32'h0000_FFF0, 1'b0, 1'b0);
    consume("or");

    run_op(4'b0110, 32'h8000_0000, 32'h0000_0001);
    check_result("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1);
    consume("sub_ovf");

    // Unsigned wrap without signed overflow
    run_op(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
    check_result("add_wrap", 32'h0, 1'b1, 1'b0);
    consume("add_wrap");

    run_op(4'b0011, 32'h1234_5678, 32'h0000_0001);
    check_result("bad_code", 32'h0, 1'b1, 1'b0);
    consume("bad_code");

    // Hold in DONE while inputs and valid_i toggle
    run_op(4'b0010, 32'd3, 32'd4);
    for (int i = 0; i < 5; i++) begin
      valid_i   = i[0];
      ALUctrl_i = 4'b0001;
      src1_i    = 32'hA5A5_0000 + i;
      src2_i    = 32'hFFFF_FFFF;
      @(posedge clk_i); #1;
      check_result($sformatf("hold%0d", i), 32'd7, 1'b0, 1'b0);
    end
    // Release with a new request pending: must not be accepted this cycle
    valid_i   = 1'b1;
    ALUctrl_i = 4'b0010;
    src1_i    = 32'd10;
    src2_i    = 32'd20;
    ready_i   = 1'b1;
    @(posedge clk_i); #1;
    ready_i   = 1'b0;
    check("release_valid", valid_o, 1'b0);
    check("release_ready", ready_o, 1'b1);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    check_result("next_accept", 32'd30, 1'b0, 1'b0);
    consume("next_accept");

`ifdef ALU_MUL_EN
    mul_op("mul_zero", 32'h0001_0000, 32'h0001_0000, 32'h0);
    mul_op("mul_small", 32'd7, 32'd6, 32'd42);
    mul_op("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);

    // Reset mid-multiply must discard the operation
    run_op(4'b1000, 32'd3, 32'd5);
    repeat (9) @(posedge clk_i);
    #1;
    check("midmul_busy", ready_o, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midmul_rst_valid", valid_o, 1'b0);
    check("midmul_rst_ready", ready_o, 1'b1);
    @(posedge clk_i); #1;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (valid_o !== 1'b0) bad++;
    end
    check("midmul_no_late", bad, 0);
    check("midmul_ready", ready_o, 1'b1);
`else
    // Multiply compiled out: code 1000 is an unknown op with latency 1
    run_op(4'b1000, 32'h0001_0000, 32'h0001_0000);
    check_result("mul_off", 32'h0, 1'b1, 1'b0);
    consume("mul_off");
    run_op(4'b1000, 32'd7, 32'd6);
    check_result("mul_off_nz", 32'h0, 1'b1, 1'b0);
    consume("mul_off_nz");
`endif

    // Reset while a result waits in DONE
    run_op(4'b0010, 32'd1, 32'd1);
    check_result("pre_rst", 32'd2, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("done_rst_valid", valid_o, 1'b0);
    check("done_rst_ready", ready_o, 1'b1);
    check("done_rst_result", result_o, 32'h0);
    @(posedge clk_i); #1;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      if (valid_o !== 1'b0) bad++;
    end
    check("done_rst_no_late", bad, 0);

    // Unit still functional after reset
    run_op(4'b0010, 32'd2, 32'd2);
    check_result("post_rst", 32'd4, 1'b0, 1'b0);
    consume("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width in bits.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 SHALL have port valid_i  input  1  upstream operation request.
REQ-005 SHALL have port ready_o  output  1  unit can accept an operation this cycle.
REQ-006 SHALL have port ALUctrl_i  input  4  ALU control code from the ALU control decoder.
REQ-007 SHALL have port src1_i  input  DATA_W  operand A.
REQ-008 SHALL have port src2_i  input  DATA_W  operand B.
REQ-009 SHALL have port valid_o  output  1  result_o/zero_o/ovf_o hold a completed result.
REQ-010 SHALL have port ready_i  input  1  downstream accepts the result.
REQ-011 SHALL have port result_o  output  DATA_W  registered result.
REQ-012 SHALL have port zero_o  output  1  result_o == 0 (for BEQ).
REQ-013 SHALL have port ovf_o  output  1  signed overflow of ADD/SUB; 0 for all other codes.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DONE.
REQ-015 ready_o SHALL be 1 only in IDLE; accept = valid_i && ready_o.
REQ-016 On accept, ALUctrl_i/src1_i/src2_i SHALL be captured; input changes after accept SHALL have no effect.
REQ-017 Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1 or 0).
REQ-018 Any other code (1000 when multiply compiled out) SHALL produce result 0, zero_o 1, ovf_o 0.
REQ-019 ADD/SUB SHALL wrap modulo 2^DATA_W; ovf_o set on signed overflow.
REQ-020 Non-multiply ops: IDLE -> DONE on accept; valid_o rises the cycle after accept (latency 1).
REQ-021 DONE SHALL hold valid_o=1 and all result outputs stable until ready_i=1.
REQ-022 DONE with ready_i=1 SHALL return to IDLE; no new accept in that same cycle (max one op per 2 cycles).
REQ-023 valid_i in any state other than IDLE SHALL be ignored (no queueing).
REQ-024 zero_o SHALL be computed from the registered result, valid whenever valid_o=1.

Reset
REQ-025 rst_n low SHALL force state IDLE immediately, asynchronously, including mid-MUL or in DONE.
REQ-026 Reset values: ready_o 1 after reset release, valid_o 0, result_o 0, zero_o 1, ovf_o 0, multiply counter 0.
REQ-027 A result pending in DONE at reset SHALL be discarded; no valid_o pulse after release.

Configuration
REQ-028 Macro ALU_MUL_EN SHALL gate the multiply feature.
REQ-029 With ALU_MUL_EN: code 1000 = MUL, low DATA_W bits of unsigned product, iterative shift-add, one bit per cycle; accept -> MUL for DATA_W cycles -> DONE; valid_o rises DATA_W+1 cycles after accept; ovf_o 0.
REQ-030 Without ALU_MUL_EN: MUL state and counter absent, code 1000 handled per REQ-018, every op latency 1.

Structure
REQ-031 Shared package alu_pkg SHALL hold the 4-bit ALU control code constants (shared with the ALU control decoder) and the FSM state enum.
REQ-032 Multiplier SHALL be sub-module alu_mul_iter (start, busy, done, product), instantiated only under ALU_MUL_EN.

Verification
REQ-033 ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, ovf_o 1, zero_o 0, valid_o one cycle after accept.
REQ-034 SUB 5 - 5 -> result 0, zero_o 1; SLT 0xFFFFFFFF vs 1 -> result 1; AND 0xF0F0 & 0xFF00 -> 0xF000.
REQ-035 Hold ready_i=0 for 5 cycles in DONE, toggle inputs and valid_i -> outputs unchanged, ready_o 0; ready_i=1 -> IDLE next cycle.
REQ-036 ALU_MUL_EN: MUL 0x00010000 * 0x00010000 -> 0, zero_o 1, valid_o at accept+33; without macro same stimulus -> result 0 at accept+1.
REQ-037 Assert rst_n low mid-MUL (cycle 10) -> valid_o 0, ready_o 1 after release, no late result.
